// File: rtl/alu_pkg.sv
// Shared types and helpers for the two-requester ALU scheduler.
package alu_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_MUL = 3'b010,
    ALU_DIV = 3'b011,
    ALU_ASR = 3'b100,
    ALU_LSR = 3'b101,
    ALU_LSL = 3'b110,
    ALU_DEF = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } sched_state_e;

  // Cycles the operands must stay on the ALU for a given op.
  function automatic logic [CNT_W-1:0] op_latency(input logic [2:0] op,
                                                  input int mul_cyc,
                                                  input int div_cyc);
    logic [CNT_W-1:0] lat;
    case (alu_op_e'(op))
      ALU_MUL: lat = CNT_W'(mul_cyc);
      ALU_DIV: lat = CNT_W'(div_cyc);
      default: lat = CNT_W'(1);
    endcase
    return lat;
  endfunction

endpackage

// File: rtl/alu_sched_if.sv
// Requester/response handshake bundle between the two requesters and the scheduler.
interface alu_sched_if #(parameter int WIDTH = 32);

  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req_a0;
  logic [WIDTH-1:0] req_b0;
  logic [2:0]       req_op0;
  logic [WIDTH-1:0] req_a1;
  logic [WIDTH-1:0] req_b1;
  logic [2:0]       req_op1;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [WIDTH-1:0] rsp_c;
  logic             rsp_z;
  logic             rsp_n;
  logic             rsp_err;

  modport master (
    output req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1, rsp_ready,
    input  req_ready, rsp_valid, rsp_c, rsp_z, rsp_n, rsp_err
  );

  modport slave (
    input  req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1, rsp_ready,
    output req_ready, rsp_valid, rsp_c, rsp_z, rsp_n, rsp_err
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester not served last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  // Grant decode from request vector and last-served pointer.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_sched.sv
// Arbitrates two requesters onto one ALU, holds operands for a multicycle window, returns results.
module alu_sched
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_CYC = 2,
  parameter int DIV_CYC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_sched_if.slave       bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_c,
  input  logic             alu_z,
  input  logic             alu_n,
  output logic             busy
);

  sched_state_e     state_r, state_s;
  logic [CNT_W-1:0] cnt_r;
  logic             owner_r, last_r, div0_r;
  logic [1:0]       grant_s, rsp_valid_r;
  logic [WIDTH-1:0] sel_a_s, sel_b_s, rsp_c_r;
  logic [2:0]       sel_op_s;
  logic             sel_div0_s, accept_s, rsp_z_r, rsp_n_r, rsp_err_r, busy_r;

  rr_arb2 u_arb (
    .req   (bus.req_valid),
    .last  (last_r),
    .grant (grant_s)
  );

  // Next state, handshake decode and operand mux for the granted requester.
  always_comb begin
    state_s       = state_r;
    bus.req_ready = 2'b00;
    accept_s      = 1'b0;
    sel_a_s       = grant_s[1] ? bus.req_a1  : bus.req_a0;
    sel_b_s       = grant_s[1] ? bus.req_b1  : bus.req_b0;
    sel_op_s      = grant_s[1] ? bus.req_op1 : bus.req_op0;
    sel_div0_s    = (sel_op_s == 3'(ALU_DIV)) && (sel_b_s == '0);
    case (state_r)
      ST_IDLE: begin
        bus.req_ready = grant_s;
        if (|grant_s) begin
          accept_s = 1'b1;
          state_s  = ST_EXEC;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (cnt_r == CNT_W'(1)) state_s = ST_RESP;
        else                    state_s = ST_EXEC;
      end
      ST_RESP: begin
        if (bus.rsp_ready[owner_r]) state_s = ST_IDLE;
        else                        state_s = ST_RESP;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Control registers: state, hold counter, owner and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      owner_r     <= 1'b0;
      last_r      <= 1'b1;
      div0_r      <= 1'b0;
      busy_r      <= 1'b0;
      rsp_valid_r <= 2'b00;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != ST_IDLE);
      if (accept_s) begin
        owner_r <= grant_s[1];
        div0_r  <= sel_div0_s;
        // Divide by zero never touches the ALU result, so one cycle suffices.
        cnt_r   <= sel_div0_s ? CNT_W'(1) : op_latency(sel_op_s, MUL_CYC, DIV_CYC);
      end else if (state_r == ST_EXEC) begin
        cnt_r <= cnt_r - CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
      if (state_r == ST_EXEC && state_s == ST_RESP) begin
        rsp_valid_r <= owner_r ? 2'b10 : 2'b01;
      end else if (state_r == ST_RESP && state_s == ST_IDLE) begin
        rsp_valid_r <= 2'b00;
        last_r      <= owner_r;
      end else begin
        rsp_valid_r <= rsp_valid_r;
      end
    end
  end

  // Datapath registers: ALU operands held from accept, result captured at end of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= 3'b000;
      rsp_c_r   <= '0;
      rsp_z_r   <= 1'b0;
      rsp_n_r   <= 1'b0;
      rsp_err_r <= 1'b0;
    end else begin
      if (accept_s) begin
        alu_a   <= sel_a_s;
        alu_b   <= sel_b_s;
        alu_sel <= sel_op_s;
      end
      if (state_r == ST_EXEC && state_s == ST_RESP) begin
        rsp_c_r   <= div0_r ? '1   : alu_c;
        rsp_z_r   <= div0_r ? 1'b0 : alu_z;
        rsp_n_r   <= div0_r ? 1'b0 : alu_n;
        rsp_err_r <= div0_r;
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_c     = rsp_c_r;
  assign bus.rsp_z     = rsp_z_r;
  assign bus.rsp_n     = rsp_n_r;
  assign bus.rsp_err   = rsp_err_r;
  assign busy          = busy_r;

endmodule
